hqm_devtlb_rst_seq: RTL



---
 rtl/hqm_devtlb_rst_seq.sv | 127 ++++++++++++
 1 files changed

// File: rtl/hqm_devtlb_rst_seq.sv
// devtlb reset sequencer: stretches the incoming reset, sweeps an invalidate over every
// array entry, then releases traffic; also runs a CSR soft reset with a req/ack handshake.
module hqm_devtlb_rst_seq #(
    parameter int NUM_ENTRIES = 64,
    parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1,
    parameter int STRETCH_CYC = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             soft_rst_req,
    output logic             soft_rst_ack,
    input  logic             pending_idle,
    output logic             pipe_rst_b,
    output logic             inv_vld,
    output logic [IDX_W-1:0] inv_idx,
    input  logic             inv_stall,
    output logic             req_block,
    output logic             init_done
);

    localparam int CNT_W = (STRETCH_CYC > 1) ? $clog2(STRETCH_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

    typedef enum logic [2:0] {
        ST_STRETCH,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_ACK
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             soft_flag, soft_flag_nxt;
    logic             pipe_rst_b_nxt;
    logic             inv_vld_nxt;
    logic [IDX_W-1:0] inv_idx_nxt;
    logic             init_done_nxt;
    logic             soft_rst_ack_nxt;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state        <= ST_STRETCH;
            cnt          <= '0;
            soft_flag    <= 1'b0;
            pipe_rst_b   <= 1'b0;
            inv_vld      <= 1'b0;
            inv_idx      <= '0;
            req_block    <= 1'b1;
            init_done    <= 1'b0;
            soft_rst_ack <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            soft_flag    <= soft_flag_nxt;
            pipe_rst_b   <= pipe_rst_b_nxt;
            inv_vld      <= inv_vld_nxt;
            inv_idx      <= inv_idx_nxt;
            req_block    <= ~init_done_nxt;
            init_done    <= init_done_nxt;
            soft_rst_ack <= soft_rst_ack_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        soft_flag_nxt    = soft_flag;
        pipe_rst_b_nxt   = pipe_rst_b;
        inv_vld_nxt      = inv_vld;
        inv_idx_nxt      = inv_idx;
        init_done_nxt    = init_done;
        soft_rst_ack_nxt = soft_rst_ack;
        unique case (state)
            ST_STRETCH: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt        = '0;
                    pipe_rst_b_nxt = 1'b1;
                    inv_vld_nxt    = 1'b1;
                    inv_idx_nxt    = '0;
                    state_nxt      = ST_INIT;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_INIT: begin
                if (inv_vld && !inv_stall) begin
                    if (inv_idx == IDX_LAST) begin
                        inv_vld_nxt      = 1'b0;
                        inv_idx_nxt      = '0;
                        init_done_nxt    = 1'b1;
                        soft_rst_ack_nxt = soft_flag;
                        state_nxt        = soft_flag ? ST_ACK : ST_RUN;
                    end else begin
                        inv_idx_nxt = inv_idx + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                // init_done drops with req_block so the two stay complementary through the drain
                if (soft_rst_req) begin
                    soft_flag_nxt = 1'b1;
                    init_done_nxt = 1'b0;
                    state_nxt     = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pending_idle) begin
                    pipe_rst_b_nxt = 1'b0;
                    init_done_nxt  = 1'b0;
                    cnt_nxt        = '0;
                    state_nxt      = ST_STRETCH;
                end
            end
            ST_ACK: begin
                if (!soft_rst_req) begin
                    soft_rst_ack_nxt = 1'b0;
                    soft_flag_nxt    = 1'b0;
                    state_nxt        = ST_RUN;
                end
            end
            default: state_nxt = ST_STRETCH;
        endcase
    end

endmodule
